dmem_handshake_responder: RTL and testbench
===========================================

Name: dmem_handshake_responder

Overview:
- Multi-cycle data memory that answers the pipelined CPU's MEM-stage load/store requests through a request/ready handshake.
- Replaces the zero-latency data memory in the MEM stage.
- Drives a stall signal, which the CPU uses to freeze PC, IF/ID, ID/EX and EX/MEM and to bubble MEM/WB until ready_o.
- Word-organised storage; configurable fixed access latency.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit words stored; power of two.
- ADDR_W, 7, word-index width, equal to log2(DEPTH_WORDS).
- LATENCY, 2, cycles from request acceptance to ready_o; legal range 1..15.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous reset, active-low.
- req_i  input  1  access request (MemRead | MemWrite from EX/MEM), level-held by CPU until ready_o.
- we_i  input  1  1 = store, 0 = load; sampled with req_i.
- addr_i  input  32  byte address (ALU result).
- wdata_i  input  32  store data.
- rdata_o  output  32  load data, valid in the ready_o cycle.
- ready_o  output  1  one-cycle pulse: access complete.
- stall_o  output  1  combinational: CPU must hold its pipeline this cycle.

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE, counter=0.
  - rdata_o=0, ready_o=0.
  - Captured addr/we/wdata = 0.
  - All memory words = 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - With req_i=1: capture word index addr_i[ADDR_W+1:2], we_i and wdata_i.
  - Load counter with LATENCY-1.
  - Next state is WAIT if LATENCY>1, else DONE.
  - stall_o = req_i.
- WAIT:
  - Counter decrements each cycle. When counter reaches 1, next state is DONE.
  - stall_o=1.
  - req_i, we_i, addr_i and wdata_i are ignored; only the captured values are used.
- DONE:
  - ready_o=1 and stall_o=0.
  - Store: captured wdata is written at the captured index on this clock edge.
  - Load: rdata_o = memory[captured index], registered on entry to DONE.
  - Next state is always IDLE.
  - req_i still high in the following IDLE cycle is treated as a new request.
- Latency:
  - ready_o asserts exactly LATENCY cycles after the IDLE cycle in which req_i was first seen high.
  - stall_o is high for LATENCY consecutive cycles, starting in that same cycle.
- rdata_o:
  - Holds its last load value through stores and idle cycles.
  - Changes only on entry to DONE for a load.
- Addressing:
  - addr_i[1:0] is ignored.
  - Byte addresses beyond DEPTH_WORDS*4 wrap modulo the depth, via index truncation.
- Read-after-write: a load issued in the cycle after a store's DONE returns the new data.
- req_i=0 in IDLE: no state change, stall_o=0, ready_o=0.
- Reset mid-access: the access is abandoned and ready_o never pulses. A pending store is not written. The memory is cleared.
- No outstanding-request queue: exactly one access is in flight.

Optional Feature:
- Macro: DMEM_MISALIGN_CHK_EN.
- Defined: adds output err_o (1 bit, reset 0).
  - err_o pulses alongside ready_o when the captured addr_i[1:0] != 0.
  - A misaligned store is suppressed, with no memory write.
  - A misaligned load returns 32'hDEAD_BEEF on rdata_o.
- Not defined:
  - No err_o port.
  - Low address bits are silently ignored, as above.

Test Plan:
- Reset/idle: hold rst_i=0 for 3 cycles, then release with req_i=0 → rdata_o=0, ready_o=0, stall_o=0 for 10 cycles.
- Store then load, LATENCY=2: store 32'h1234_5678 to address 0x40.
  - Expect stall_o high 2 cycles and ready_o in cycle 2.
  - Then load 0x40 → rdata_o=32'h1234_5678 with ready_o, 2 cycles after the request.
- Latency sweep: LATENCY=1, 3 and 15.
  - stall_o high exactly LATENCY cycles and ready_o a single pulse each time.
  - With LATENCY=1, ready_o comes one cycle after the request.
- Input churn during WAIT: request a load at 0x8.
  - During WAIT, change addr_i to 0x10 and we_i to 1.
  - → Data from 0x8 is returned; no write occurs at 0x10.
- Wrap and back-to-back (DEPTH_WORDS=128): store 32'hA5A5_A5A5 at 0x200, then immediately load 0x0 while req_i stays high → load returns 32'hA5A5_A5A5, with a second ready_o LATENCY cycles after the first.
- Reset mid-WAIT: store 32'hFFFF_FFFF to 0x4, assert rst_i=0 during WAIT → ready_o never pulses; a subsequent load of 0x4 returns 0.
  - With DMEM_MISALIGN_CHK_EN: load 0x6 → err_o=1 and rdata_o=32'hDEAD_BEEF.

Source files
------------

// File: rtl/dmem_handshake_responder.sv
// Multi-cycle word-organised data memory answering MEM-stage loads/stores via req/ready, with pipeline stall.
// Define DMEM_MISALIGN_CHK_EN to add err_o and misaligned-access suppression.
module dmem_handshake_responder #(
   parameter int DEPTH_WORDS = 128,
   parameter int ADDR_W      = 7,
   parameter int LATENCY     = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        ready_o,
`ifdef DMEM_MISALIGN_CHK_EN
   output logic        err_o,
`endif
   output logic        stall_o
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [1:0]        lo_q, lo_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       mem_q [DEPTH_WORDS];

   logic [ADDR_W-1:0] rd_idx;
   logic              rd_we;
   logic              mem_we;
`ifdef DMEM_MISALIGN_CHK_EN
   logic [1:0]        rd_lo;
   logic              unused_bits;
   assign unused_bits = ^addr_i[31:ADDR_W+2];
`else
   logic              unused_bits;
   assign unused_bits = ^{addr_i[31:ADDR_W+2], lo_q};
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      lo_d    = lo_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      rd_idx  = idx_q;
      rd_we   = we_q;
`ifdef DMEM_MISALIGN_CHK_EN
      rd_lo   = lo_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               idx_d   = addr_i[ADDR_W+1:2];
               lo_d    = addr_i[1:0];
               we_d    = we_i;
               wdata_d = wdata_i;
               cnt_d   = CNT_INIT;
               state_d = (LATENCY > 1) ? S_WAIT : S_DONE;
               // With LATENCY=1 DONE is entered straight from IDLE, so the read uses the live request.
               rd_idx  = addr_i[ADDR_W+1:2];
               rd_we   = we_i;
`ifdef DMEM_MISALIGN_CHK_EN
               rd_lo   = addr_i[1:0];
`endif
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end
            if (cnt_q <= 4'd1) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if ((state_d == S_DONE) && (state_q != S_DONE) && !rd_we) begin
         rdata_d = mem_q[rd_idx];
`ifdef DMEM_MISALIGN_CHK_EN
         if (rd_lo != 2'b00) begin
            rdata_d = 32'hDEAD_BEEF;
         end
`endif
      end
   end

`ifdef DMEM_MISALIGN_CHK_EN
   assign mem_we = (state_q == S_DONE) && we_q && (lo_q == 2'b00);
`else
   assign mem_we = (state_q == S_DONE) && we_q;
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         lo_q    <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         lo_q    <= lo_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage must clear on reset, so each word is its own resettable register.
   for (genvar gi = 0; gi < DEPTH_WORDS; gi++) begin : g_mem
      always_ff @(posedge clk_i or negedge rst_i) begin
         if (!rst_i) begin
            mem_q[gi] <= '0;
         end else if (mem_we && (idx_q == ADDR_W'(gi))) begin
            mem_q[gi] <= wdata_q;
         end
      end
   end

   assign rdata_o = rdata_q;
   assign ready_o = (state_q == S_DONE);
   assign stall_o = ((state_q == S_IDLE) && req_i) || (state_q == S_WAIT);
`ifdef DMEM_MISALIGN_CHK_EN
   assign err_o   = (state_q == S_DONE) && (lo_q != 2'b00);
`endif

endmodule

// File: tb/tb_dmem_handshake_responder.sv
// Self-checking bench: four responders at LATENCY 1, 2, 3 and 15 driven independently, scoreboard-checked.
module tb_dmem_handshake_responder;

   localparam int NDUT = 4;
   localparam int LAT0 = 1;
   localparam int LAT1 = 2;
   localparam int LAT2 = 3;
   localparam int LAT3 = 15;

   logic            clk;
   logic            rst_n;
   logic [NDUT-1:0] req_r, we_r, ready_w, stall_w, err_w;
   logic [31:0]     addr_r  [NDUT];
   logic [31:0]     wdata_r [NDUT];
   logic [31:0]     rdata_w [NDUT];

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int          lat;
      logic [31:0] data;
      bit          chk_data;
      logic        err;
   } exp_t;
   exp_t sb[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      dmem_handshake_responder #(
         .DEPTH_WORDS(128),
         .ADDR_W     (7),
         .LATENCY    (gi == 0 ? LAT0 : gi == 1 ? LAT1 : gi == 2 ? LAT2 : LAT3)
      ) u_dut (
         .clk_i  (clk),
         .rst_i  (rst_n),
         .req_i  (req_r[gi]),
         .we_i   (we_r[gi]),
         .addr_i (addr_r[gi]),
         .wdata_i(wdata_r[gi]),
         .rdata_o(rdata_w[gi]),
         .ready_o(ready_w[gi]),
`ifdef DMEM_MISALIGN_CHK_EN
         .err_o  (err_w[gi]),
`endif
         .stall_o(stall_w[gi])
      );
`ifndef DMEM_MISALIGN_CHK_EN
      assign err_w[gi] = 1'b0;
`endif
   end

   function automatic int lat_of(input int k);
      case (k)
         0:       return LAT0;
         1:       return LAT1;
         2:       return LAT2;
         default: return LAT3;
      endcase
   endfunction

   // Drives one request (req left high afterwards) and reports what the DUT did until ready_o.
   task automatic run_access(input int k, input logic we, input logic [31:0] addr,
                             input logic [31:0] wd, input bit churn,
                             output int stall_cnt, output int ready_cyc,
                             output logic [31:0] rd, output logic err);
      int c;
      c = 0; stall_cnt = 0; ready_cyc = -1; rd = '0; err = 1'b0;
      @(posedge clk); #1;
      req_r[k] = 1'b1; we_r[k] = we; addr_r[k] = addr; wdata_r[k] = wd;
      forever begin
         @(negedge clk);
         if (stall_w[k]) stall_cnt++;
         if (ready_w[k]) begin
            ready_cyc = c; rd = rdata_w[k]; err = err_w[k];
            break;
         end
         c++;
         if (c > 40) break;
         @(posedge clk); #1;
         if (churn && c == 1) begin
            addr_r[k] = 32'h10; we_r[k] = 1'b1; wdata_r[k] = 32'hBAD0_BAD0;
         end
      end
   endtask

   task automatic idle(input int k, input int n, output int rdy, output int stl);
      @(posedge clk); #1;
      req_r[k] = 1'b0; we_r[k] = 1'b0;
      rdy = 0; stl = 0;
      repeat (n) begin
         @(negedge clk);
         if (ready_w[k]) rdy++;
         if (stall_w[k]) stl++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if ({rdata_w[k], ready_w[k], stall_w[k]} !== 34'd0) begin
               n_fail++;
               $display("FAIL reset_idle dut%0d cyc%0d: rdata=%h ready=%b stall=%b, required 0/0/0",
                        k, cyc, rdata_w[k], ready_w[k], stall_w[k]);
            end
         end
      end
   endtask

   task automatic test_store_load();
      int sc, rc, rdy, stl; logic [31:0] rd; logic er; exp_t e;
      sb.push_back('{lat: LAT1, data: 32'h0, chk_data: 1'b0, err: 1'b0});
      run_access(1, 1'b1, 32'h40, 32'h1234_5678, 1'b0, sc, rc, rd, er);
      e = sb.pop_front();
      n_checks++;
      if (sc !== e.lat || rc !== e.lat) begin
         n_fail++;
         $display("FAIL store_lat: stall_cycles=%0d ready_cycle=%0d, required %0d/%0d", sc, rc, e.lat, e.lat);
      end
      idle(1, 2, rdy, stl);
      n_checks++;
      if (rdy !== 0) begin
         n_fail++;
         $display("FAIL store_ready_pulse: extra ready=%0d, required 0", rdy);
      end
      sb.push_back('{lat: LAT1, data: 32'h1234_5678, chk_data: 1'b1, err: 1'b0});
      run_access(1, 1'b0, 32'h40, 32'h0, 1'b0, sc, rc, rd, er);
      e = sb.pop_front();
      n_checks++;
      if (rc !== e.lat || rd !== e.data) begin
         n_fail++;
         $display("FAIL load_40: ready_cycle=%0d rdata=%h, required %0d/%h", rc, rd, e.lat, e.data);
      end
      idle(1, 1, rdy, stl);
      run_access(1, 1'b1, 32'h44, 32'h0BAD_0044, 1'b0, sc, rc, rd, er);
      n_checks++;
      if (rd !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL rdata_hold_on_store: rdata=%h, required %h", rd, 32'h1234_5678);
      end
      idle(1, 1, rdy, stl);
   endtask

   task automatic test_latency_sweep();
      int sc, rc, rdy, stl; logic [31:0] rd; logic er; exp_t e;
      for (int k = 0; k < NDUT; k++) begin
         run_access(k, 1'b1, 32'h80 + 32'(k * 4), 32'h5EED_0000 + 32'(k), 1'b0, sc, rc, rd, er);
         idle(k, 3, rdy, stl);
         sb.push_back('{lat: lat_of(k), data: 32'h5EED_0000 + 32'(k), chk_data: 1'b1, err: 1'b0});
         run_access(k, 1'b0, 32'h80 + 32'(k * 4), 32'h0, 1'b0, sc, rc, rd, er);
         e = sb.pop_front();
         n_checks++;
         if (sc !== e.lat || rc !== e.lat || rd !== e.data) begin
            n_fail++;
            $display("FAIL sweep_lat%0d: stall=%0d ready_cycle=%0d rdata=%h, required %0d/%0d/%h",
                     e.lat, sc, rc, rd, e.lat, e.lat, e.data);
         end
         idle(k, 3, rdy, stl);
         n_checks++;
         if (rdy !== 0 || stl !== 0) begin
            n_fail++;
            $display("FAIL sweep_single_pulse_lat%0d: ready=%0d stall=%0d after access, required 0/0",
                     e.lat, rdy, stl);
         end
      end
   endtask

   task automatic test_churn();
      int sc, rc, rdy, stl; logic [31:0] rd; logic er; exp_t e;
      run_access(2, 1'b1, 32'h8, 32'hCAFE_0008, 1'b0, sc, rc, rd, er);
      idle(2, 1, rdy, stl);
      run_access(2, 1'b1, 32'h10, 32'h1111_0010, 1'b0, sc, rc, rd, er);
      idle(2, 1, rdy, stl);
      sb.push_back('{lat: LAT2, data: 32'hCAFE_0008, chk_data: 1'b1, err: 1'b0});
      run_access(2, 1'b0, 32'h8, 32'h0, 1'b1, sc, rc, rd, er);
      e = sb.pop_front();
      n_checks++;
      if (rc !== e.lat || rd !== e.data) begin
         n_fail++;
         $display("FAIL churn_load_8: ready_cycle=%0d rdata=%h, required %0d/%h", rc, rd, e.lat, e.data);
      end
      idle(2, 1, rdy, stl);
      sb.push_back('{lat: LAT2, data: 32'h1111_0010, chk_data: 1'b1, err: 1'b0});
      run_access(2, 1'b0, 32'h10, 32'h0, 1'b0, sc, rc, rd, er);
      e = sb.pop_front();
      n_checks++;
      if (rd !== e.data) begin
         n_fail++;
         $display("FAIL churn_no_write_10: rdata=%h, required %h", rd, e.data);
      end
      idle(2, 1, rdy, stl);
   endtask

   task automatic test_back_to_back();
      int sc, rc, rdy, stl; logic [31:0] rd; logic er; exp_t e;
      sb.push_back('{lat: LAT1, data: 32'h0, chk_data: 1'b0, err: 1'b0});
      sb.push_back('{lat: LAT1, data: 32'hA5A5_A5A5, chk_data: 1'b1, err: 1'b0});
      run_access(1, 1'b1, 32'h200, 32'hA5A5_A5A5, 1'b0, sc, rc, rd, er);
      e = sb.pop_front();
      n_checks++;
      if (rc !== e.lat) begin
         n_fail++;
         $display("FAIL b2b_store: ready_cycle=%0d, required %0d", rc, e.lat);
      end
      // req_i stays high straight into the following IDLE cycle
      run_access(1, 1'b0, 32'h0, 32'h0, 1'b0, sc, rc, rd, er);
      e = sb.pop_front();
      n_checks++;
      if (rc !== e.lat || sc !== e.lat || rd !== e.data) begin
         n_fail++;
         $display("FAIL b2b_wrap_load: gap=%0d stall=%0d rdata=%h, required %0d/%0d/%h",
                  rc, sc, rd, e.lat, e.lat, e.data);
      end
      idle(1, 2, rdy, stl);
   endtask

   task automatic test_reset_mid_wait();
      int sc, rc, rdy, stl; logic [31:0] rd; logic er; exp_t e;
      @(posedge clk); #1;
      req_r[2] = 1'b1; we_r[2] = 1'b1; addr_r[2] = 32'h4; wdata_r[2] = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      rst_n = 1'b0; req_r[2] = 1'b0; we_r[2] = 1'b0;
      rdy = 0;
      repeat (3) begin
         @(negedge clk);
         if (ready_w[2]) rdy++;
      end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (ready_w[2]) rdy++;
      end
      n_checks++;
      if (rdy !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_wait_ready: ready pulses=%0d, required 0", rdy);
      end
      sb.push_back('{lat: LAT2, data: 32'h0, chk_data: 1'b1, err: 1'b0});
      run_access(2, 1'b0, 32'h4, 32'h0, 1'b0, sc, rc, rd, er);
      e = sb.pop_front();
      n_checks++;
      if (rc !== e.lat || rd !== e.data) begin
         n_fail++;
         $display("FAIL reset_mid_wait_load_4: ready_cycle=%0d rdata=%h, required %0d/%h",
                  rc, rd, e.lat, e.data);
      end
      idle(2, 1, rdy, stl);
   endtask

`ifdef DMEM_MISALIGN_CHK_EN
   task automatic test_misalign();
      int sc, rc, rdy, stl; logic [31:0] rd; logic er; exp_t e;
      logic        we_t   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] addr_t [4] = '{32'h4, 32'h6, 32'h5, 32'h4};
      logic [31:0] wd_t   [4] = '{32'h7777_0004, 32'h0, 32'h9999_9999, 32'h0};
      sb.push_back('{lat: LAT1, data: 32'h0, chk_data: 1'b0, err: 1'b0});
      sb.push_back('{lat: LAT1, data: 32'hDEAD_BEEF, chk_data: 1'b1, err: 1'b1});
      sb.push_back('{lat: LAT1, data: 32'h0, chk_data: 1'b0, err: 1'b1});
      sb.push_back('{lat: LAT1, data: 32'h7777_0004, chk_data: 1'b1, err: 1'b0});
      for (int i = 0; i < 4; i++) begin
         run_access(1, we_t[i], addr_t[i], wd_t[i], 1'b0, sc, rc, rd, er);
         e = sb.pop_front();
         n_checks++;
         if (rc !== e.lat || er !== e.err || (e.chk_data && rd !== e.data)) begin
            n_fail++;
            $display("FAIL misalign_%0d addr=%h: ready_cycle=%0d err=%b rdata=%h, required %0d/%b/%h",
                     i, addr_t[i], rc, er, rd, e.lat, e.err, e.data);
         end
         idle(1, 1, rdy, stl);
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      req_r = '0;
      we_r  = '0;
      for (int k = 0; k < NDUT; k++) begin
         addr_r[k]  = '0;
         wdata_r[k] = '0;
      end
      test_reset();
      test_store_load();
      test_latency_sweep();
      test_churn();
      test_back_to_back();
      test_reset_mid_wait();
`ifdef DMEM_MISALIGN_CHK_EN
      test_misalign();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
